// File: rtl/rom_arbiter.sv
// rom_arbiter: two read ports (0 = instruction fetch, 1 = debug/loader)
// sharing one combinational 64x32 ROM. The block makes one ROM access per
// cycle and registers the response for each port.
// Define ROM_ARB_RR_EN to build with round-robin contention resolution.
// With it undefined, port 0 always wins on contention.
module rom_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic [5:0]  addr0,
  output logic        gnt0,
  output logic        rvalid0,
  output logic [31:0] rdata0,
  input  logic        rready0,
  input  logic        req1,
  input  logic [5:0]  addr1,
  output logic        gnt1,
  output logic        rvalid1,
  output logic [31:0] rdata1,
  input  logic        rready1,
  output logic        rom_ce,
  output logic [5:0]  rom_addr,
  input  logic [31:0] rom_inst
);

  typedef enum logic {
    PORT0 = 1'b0,
    PORT1 = 1'b1
  } port_t;

  port_t last_gnt;
  logic  elig0;
  logic  elig1;
  logic  pick1;

  // A port may take a new read when its response slot is empty or being drained.
  assign elig0 = req0 & (~rvalid0 | rready0);
  assign elig1 = req1 & (~rvalid1 | rready1);

  // Select the winner from eligibility and the priority policy.
  always_comb begin
    pick1 = 1'b0;
`ifdef ROM_ARB_RR_EN
    pick1 = elig1 & (~elig0 | (last_gnt == PORT0));
`else
    pick1 = elig1 & ~elig0;
`endif
  end

  // Drive the grants and the ROM port. Reset forces the bus idle.
  always_comb begin
    gnt0     = ~rst & elig0 & ~pick1;
    gnt1     = ~rst & pick1;
    rom_ce   = gnt0 | gnt1;
    rom_addr = '0;
    if (gnt0)
      rom_addr = addr0;
    else if (gnt1)
      rom_addr = addr1;
  end

  // Capture the ROM data for the winner and retire consumed responses.
  // A grant overrides a consume so that back-to-back reads keep rvalid high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rvalid0  <= 1'b0;
      rvalid1  <= 1'b0;
      rdata0   <= '0;
      rdata1   <= '0;
      last_gnt <= PORT1;
    end else begin
      if (gnt0) begin
        rdata0  <= rom_inst;
        rvalid0 <= 1'b1;
      end else if (rready0) begin
        rvalid0 <= 1'b0;
      end
      if (gnt1) begin
        rdata1  <= rom_inst;
        rvalid1 <= 1'b1;
      end else if (rready1) begin
        rvalid1 <= 1'b0;
      end
      last_gnt <= gnt1 ? PORT1 : (gnt0 ? PORT0 : last_gnt);
    end
  end

endmodule

// File: tb/tb_rom_arbiter.sv
// Directed testbench for rom_arbiter. Expected values come from a small ROM
// model. The contention results depend on whether ROM_ARB_RR_EN is defined.
module tb_rom_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0, req1, rready0, rready1;
  logic [5:0]  addr0, addr1;
  logic        gnt0, gnt1, rvalid0, rvalid1, rom_ce;
  logic [31:0] rdata0, rdata1, rom_inst;
  logic [5:0]  rom_addr;

  int unsigned total = 0;
  int unsigned pass = 0;

  function automatic logic [31:0] rom_val(input logic [5:0] a);
    if (a == 6'h05) return 32'h3C011234;
    return 32'hC0DE0000 | {26'h0, a};
  endfunction

  assign rom_inst = rom_val(rom_addr);

  always #5 clk = ~clk;

  rom_arbiter dut (
    .clk(clk), .rst(rst),
    .req0(req0), .addr0(addr0), .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0), .rready0(rready0),
    .req1(req1), .addr1(addr1), .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1), .rready1(rready1),
    .rom_ce(rom_ce), .rom_addr(rom_addr), .rom_inst(rom_inst)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic reset_pulse;
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; req0 = 1'b1; req1 = 1'b1; addr0 = 6'h11; addr1 = 6'h22;
    rready0 = 1'b0; rready1 = 1'b0;
    #1;
    total++; if (gnt0 !== 1'b0) $display("FAIL reset_gnt0 got %b exp 0", gnt0); else pass++;
    total++; if (gnt1 !== 1'b0) $display("FAIL reset_gnt1 got %b exp 0", gnt1); else pass++;
    total++; if (rom_ce !== 1'b0) $display("FAIL reset_rom_ce got %b exp 0", rom_ce); else pass++;
    total++; if (rom_addr !== 6'h00) $display("FAIL reset_rom_addr got %h exp 00", rom_addr); else pass++;
    tick();
    total++; if (gnt0 !== 1'b0 || gnt1 !== 1'b0) $display("FAIL reset_gnt_edge got %b%b exp 00", gnt0, gnt1); else pass++;
    total++; if (rvalid0 !== 1'b0 || rvalid1 !== 1'b0) $display("FAIL reset_rvalid got %b%b exp 00", rvalid0, rvalid1); else pass++;
    total++; if (rdata0 !== 32'h0) $display("FAIL reset_rdata0 got %h exp 00000000", rdata0); else pass++;
    total++; if (rdata1 !== 32'h0) $display("FAIL reset_rdata1 got %h exp 00000000", rdata1); else pass++;
    req0 = 1'b0; req1 = 1'b0; rst = 1'b0;
    #1;
  endtask

  task automatic test_single;
    req0 = 1'b1; addr0 = 6'h05; rready0 = 1'b1;
    #1;
    total++; if (gnt0 !== 1'b1 || gnt1 !== 1'b0) $display("FAIL single_gnt got %b%b exp 01", gnt1, gnt0); else pass++;
    total++; if (rom_ce !== 1'b1) $display("FAIL single_rom_ce got %b exp 1", rom_ce); else pass++;
    total++; if (rom_addr !== 6'h05) $display("FAIL single_rom_addr got %h exp 05", rom_addr); else pass++;
    total++; if (rvalid0 !== 1'b0) $display("FAIL single_rvalid_early got %b exp 0", rvalid0); else pass++;
    tick();
    req0 = 1'b0;
    total++; if (rvalid0 !== 1'b1) $display("FAIL single_rvalid got %b exp 1", rvalid0); else pass++;
    total++; if (rdata0 !== 32'h3C011234) $display("FAIL single_rdata got %h exp 3c011234", rdata0); else pass++;
    #1;
    total++; if (rom_ce !== 1'b0) $display("FAIL single_idle_ce got %b exp 0", rom_ce); else pass++;
    tick();
    total++; if (rvalid0 !== 1'b0) $display("FAIL single_consume got %b exp 0", rvalid0); else pass++;
    total++; if (rdata0 !== 32'h3C011234) $display("FAIL single_rdata_hold got %h exp 3c011234", rdata0); else pass++;
  endtask

  task automatic test_contention;
    logic exp1;
    reset_pulse();
    req0 = 1'b1; req1 = 1'b1; rready0 = 1'b1; rready1 = 1'b1;
    for (int i = 0; i < 4; i++) begin
`ifdef ROM_ARB_RR_EN
      exp1 = (i % 2) == 1;
`else
      exp1 = 1'b0;
`endif
      addr0 = 6'(10 + i); addr1 = 6'(20 + i);
      #1;
      total++; if (gnt0 !== ~exp1 || gnt1 !== exp1) $display("FAIL contend_gnt[%0d] got %b%b exp %b%b", i, gnt1, gnt0, exp1, ~exp1); else pass++;
      total++; if (rom_addr !== (exp1 ? addr1 : addr0)) $display("FAIL contend_addr[%0d] got %h exp %h", i, rom_addr, exp1 ? addr1 : addr0); else pass++;
      tick();
      if (exp1) begin
        total++; if (rvalid1 !== 1'b1 || rdata1 !== rom_val(6'(20 + i))) $display("FAIL contend_rdata1[%0d] got %b/%h exp 1/%h", i, rvalid1, rdata1, rom_val(6'(20 + i))); else pass++;
      end else begin
        total++; if (rvalid0 !== 1'b1 || rdata0 !== rom_val(6'(10 + i))) $display("FAIL contend_rdata0[%0d] got %b/%h exp 1/%h", i, rvalid0, rdata0, rom_val(6'(10 + i))); else pass++;
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    tick();
    total++; if (rvalid0 !== 1'b0 || rvalid1 !== 1'b0) $display("FAIL contend_drain got %b%b exp 00", rvalid1, rvalid0); else pass++;
  endtask

  task automatic test_backpressure;
    reset_pulse();
    req0 = 1'b1; addr0 = 6'h03; rready0 = 1'b0; rready1 = 1'b1;
    tick();
    total++; if (rvalid0 !== 1'b1 || rdata0 !== rom_val(6'h03)) $display("FAIL bp_setup got %b/%h exp 1/%h", rvalid0, rdata0, rom_val(6'h03)); else pass++;
    addr0 = 6'h07; req1 = 1'b1; addr1 = 6'h09;
    #1;
    total++; if (gnt0 !== 1'b0 || gnt1 !== 1'b1) $display("FAIL bp_gnt got %b%b exp 10", gnt1, gnt0); else pass++;
    total++; if (rom_addr !== 6'h09) $display("FAIL bp_rom_addr got %h exp 09", rom_addr); else pass++;
    tick();
    total++; if (rvalid0 !== 1'b1 || rdata0 !== rom_val(6'h03)) $display("FAIL bp_hold0 got %b/%h exp 1/%h", rvalid0, rdata0, rom_val(6'h03)); else pass++;
    total++; if (rvalid1 !== 1'b1 || rdata1 !== rom_val(6'h09)) $display("FAIL bp_rdata1 got %b/%h exp 1/%h", rvalid1, rdata1, rom_val(6'h09)); else pass++;
    rready0 = 1'b1;
    #1;
    total++; if (gnt0 !== 1'b1 || gnt1 !== 1'b0) $display("FAIL bp_release_gnt got %b%b exp 01", gnt1, gnt0); else pass++;
    total++; if (rom_addr !== 6'h07) $display("FAIL bp_release_addr got %h exp 07", rom_addr); else pass++;
    req1 = 1'b0;
    tick();
    total++; if (rvalid0 !== 1'b1 || rdata0 !== rom_val(6'h07)) $display("FAIL bp_release_rdata got %b/%h exp 1/%h", rvalid0, rdata0, rom_val(6'h07)); else pass++;
    total++; if (rvalid1 !== 1'b0) $display("FAIL bp_consume1 got %b exp 0", rvalid1); else pass++;
    req0 = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back;
    req0 = 1'b1; rready0 = 1'b1; req1 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      addr0 = 6'(i);
      #1;
      total++; if (gnt0 !== 1'b1) $display("FAIL b2b_gnt[%0d] got %b exp 1", i, gnt0); else pass++;
      tick();
      total++; if (rvalid0 !== 1'b1 || rdata0 !== rom_val(6'(i))) $display("FAIL b2b_rdata[%0d] got %b/%h exp 1/%h", i, rvalid0, rdata0, rom_val(6'(i))); else pass++;
    end
    req0 = 1'b0;
    tick();
    total++; if (rvalid0 !== 1'b0) $display("FAIL b2b_drain got %b exp 0", rvalid0); else pass++;
  endtask

  task automatic test_reset_mid;
    req1 = 1'b1; addr1 = 6'h0C; rready1 = 1'b0;
    #1;
    total++; if (gnt1 !== 1'b1) $display("FAIL rmid_gnt1 got %b exp 1", gnt1); else pass++;
    rst = 1'b1;
    #1;
    total++; if (gnt1 !== 1'b0 || rom_ce !== 1'b0) $display("FAIL rmid_gnt_rst got %b/%b exp 0/0", gnt1, rom_ce); else pass++;
    tick();
    req1 = 1'b0;
    rst = 1'b0;
    #1;
    total++; if (rvalid1 !== 1'b0 || rdata1 !== 32'h0) $display("FAIL rmid_after got %b/%h exp 0/00000000", rvalid1, rdata1); else pass++;
    tick();
    total++; if (rvalid1 !== 1'b0) $display("FAIL rmid_late got %b exp 0", rvalid1); else pass++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end

endmodule

// File: doc/rom_arbiter.md
ROM_ARBITER -- requirements
Module: rom_arbiter

Interface
REQ-001 The block SHALL have no parameters; widths are fixed at 6-bit address and 32-bit data.
REQ-002 clk  input  1  system clock; all state updates on its rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 req0  input  1  port 0 (instruction fetch) read request.
REQ-005 addr0  input  6  port 0 read address, held stable while req0=1 and gnt0=0.
REQ-006 gnt0  output  1  port 0 request accepted this cycle.
REQ-007 rvalid0  output  1  port 0 response register holds data.
REQ-008 rdata0  output  32  port 0 response data.
REQ-009 rready0  input  1  port 0 consumes response this cycle.
REQ-010 req1, addr1, gnt1, rvalid1, rdata1, rready1  same widths and meaning for port 1 (debug/loader read).
REQ-011 rom_ce  output  1  ROM enable, 1 only in a granted cycle.
REQ-012 rom_addr  output  6  address of the granted port, 0 when no grant.
REQ-013 rom_inst  input  32  combinational ROM read data for rom_addr.

Function
REQ-014 Port n SHALL be eligible in a cycle iff reqn=1 and (rvalidn=0 or rreadyn=1).
REQ-015 At most one of gnt0/gnt1 SHALL be 1 in any cycle; grant is combinational from eligibility and the priority state.
REQ-016 With both ports eligible, the winner SHALL be chosen per REQ-029/REQ-030; with one eligible, that port wins; with none, gnt0=gnt1=0, rom_ce=0.
REQ-017 In a granted cycle rom_ce=1 and rom_addr=addr of the winner.
REQ-018 At the rising edge ending a granted cycle, the winner's rdata SHALL load rom_inst and its rvalid SHALL become 1; latency request-accepted to rvalid is exactly 1 cycle.
REQ-019 rvalidn SHALL clear at the edge where rreadyn=1 and no new grant to port n occurs; rdatan holds its value while rvalidn=1 and rreadyn=0.
REQ-020 Simultaneous consume and new grant on the same port SHALL leave rvalidn=1 with the new data (back-to-back, one read per cycle per port).
REQ-021 rreadyn while rvalidn=0 SHALL be ignored.
REQ-022 A port with a full, unconsumed response SHALL not be granted; the other port may be granted that cycle.
REQ-023 Priority state last_gnt (1 bit) SHALL update only on a granted cycle, to the winner's index.
REQ-024 Sustained throughput SHALL be one ROM access per cycle total.

Reset
REQ-025 While rst=1: rvalid0=rvalid1=0, rdata0=rdata1=32'h00000000, last_gnt=1 (port 0 favoured next).
REQ-026 While rst=1: gnt0=gnt1=0, rom_ce=0, rom_addr=0, regardless of requests.
REQ-027 Reset asserted mid-access SHALL discard the in-flight read; no rvalid follows after reset release.
REQ-028 First eligible cycle after rst falls SHALL be arbitrated normally.

Configuration
REQ-029 With ROM_ARB_RR_EN defined: on contention the port not equal to last_gnt wins (round robin).
REQ-030 Without ROM_ARB_RR_EN: on contention port 0 always wins; last_gnt is still maintained but unused.

Verification
REQ-031 Reset: rst=1 with req0=req1=1 -> gnt0=gnt1=0, rom_ce=0, rvalid0=rvalid1=0, rdata=0.
REQ-032 Single read: req0=1, addr0=6'h05, rom_inst=32'h3C011234 -> gnt0=1, rom_addr=5 same cycle; next cycle rvalid0=1, rdata0=32'h3C011234.
REQ-033 Contention, RR build: req0=req1=1 held for 4 cycles, rready0=rready1=1 -> grants 0,1,0,1; fixed build -> grants 0,0,0,0.
REQ-034 Backpressure: rvalid0=1, rready0=0, req0=1, req1=1 -> gnt1=1, gnt0=0; rdata0 unchanged; raising rready0 -> gnt0=1 next arbitration.
REQ-035 Back-to-back: req0=1, rready0=1, addr0 0,1,2 on consecutive cycles -> rdata0 = rom[0], rom[1], rom[2] on consecutive cycles, rvalid0 stays 1.
REQ-036 Reset mid-access: gnt1=1 cycle, rst rises before the edge -> rvalid1=0 after reset, no stale data.
